// File: rtl/shift_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// shift_unit_pipe_if
// Operand/result bus for shift_unit_pipe: valid/ready input side carrying the
// operand, shift amount, mode and user tag, and a valid/ready output side
// carrying the shifted result and its tag.
//
// Parameters : DW  data width, SHW shift-amount width, TW tag width
// Signals    : in_valid/in_ready/in_data/in_amt/in_mode/in_tag   (issue side)
//              out_valid/out_ready/out_data/out_tag              (result side)
// Modports   : master - issue logic / result consumer (drives in_*, out_ready)
//              slave  - the shifter pipeline
// -----------------------------------------------------------------------------
interface shift_unit_pipe_if #(
  parameter int DW  = 16,
  parameter int SHW = 4,
  parameter int TW  = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [SHW-1:0] in_amt;
  logic [1:0]     in_mode;
  logic [TW-1:0]  in_tag;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [TW-1:0]  out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// -----------------------------------------------------------------------------
// shift_unit_pipe
// Pipelined multi-mode shifter (arithmetic right, logical right, left, rotate
// right) with valid/ready flow control. The shift amount is decomposed into its
// binary digits; each of the NSTG register stages applies an even share of
// those digits, least-significant digits first. Mode, remaining amount and the
// user tag ride along with the data in every stage.
//
// Parameters : DW   data width (>=2)
//              SHW  shift-amount width (amounts >= DW are legal)
//              NSTG number of pipeline register stages, 1..SHW
//              TW   tag width
// Ports      : clk    rising-edge clock
//              rst_n  asynchronous active-low reset (flushes all stages)
//              bus    shift_unit_pipe_if.slave
//                     in_mode: 00 ARSH, 01 LRSH, 10 LSH, 11 ROR
// Build macro: SHIFT_ROUND_EN - when defined, ARSH rounds half-up by adding
//              the last bit shifted out; otherwise ARSH truncates toward -inf.
// -----------------------------------------------------------------------------
module shift_unit_pipe #(
  parameter int DW   = 16,
  parameter int SHW  = 4,
  parameter int NSTG = 2,
  parameter int TW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_unit_pipe_if.slave  bus
);

  localparam logic [1:0] MODE_ARSH = 2'b00;
  localparam logic [1:0] MODE_LRSH = 2'b01;
  localparam logic [1:0] MODE_LSH  = 2'b10;
  localparam logic [1:0] MODE_ROR  = 2'b11;

  // Apply the amount digits owned by stage stg to d. Amounts reaching here are
  // already below DW, so every partial step is a plain in-range shift/rotate.
  function automatic logic [DW-1:0] f_shift_step(
    input logic [DW-1:0]  d,
    input logic [SHW-1:0] amt,
    input logic [1:0]     mode,
    input int             stg
  );
    logic [DW-1:0]        x;
    logic signed [DW-1:0] xs;
    int                   lo;
    int                   hi;
    int                   sh;
    x  = d;
    lo = (stg * SHW) / NSTG;
    hi = ((stg + 1) * SHW) / NSTG;
    for (int b = 0; b < SHW; b++) begin
      if (b >= lo && b < hi && amt[b]) begin
        sh = 1 << b;
        if (sh < DW) begin
          case (mode)
            MODE_ARSH: begin
              xs = x;
              x  = xs >>> sh;
            end
            MODE_LRSH: x = x >> sh;
            MODE_LSH:  x = x << sh;
            default:   x = (x >> sh) | (x << (DW - sh));
          endcase
        end
      end
    end
    return x;
  endfunction

`ifdef SHIFT_ROUND_EN
  // Last bit shifted out by an arithmetic right shift of p: data[p-1] for
  // 1 <= p <= DW-1. The mask collapses to zero for p = 0 and for p >= DW.
  function automatic logic f_round_bit(
    input logic [DW-1:0]  d,
    input logic [SHW-1:0] p
  );
    logic [DW-1:0] mask;
    mask = (DW'(1) << p) >> 1;
    return |(d & mask);
  endfunction

  function automatic logic [DW-1:0] f_round_add(
    input logic [DW-1:0] d,
    input logic          r
  );
    return d + DW'(r);
  endfunction
`endif

  // Pipeline state
  logic [NSTG-1:0] r_vld_p;
  logic [DW-1:0]   r_data_p [NSTG];
  logic [SHW-1:0]  r_amt_p  [NSTG];
  logic [1:0]      r_mode_p [NSTG];
  logic [TW-1:0]   r_tag_p  [NSTG];
`ifdef SHIFT_ROUND_EN
  logic [NSTG-1:0] r_rnd_p;
  logic [NSTG-1:0] w_src_rnd;
`endif

  // Per-stage source (what the stage would load) and load value
  logic [NSTG-1:0] w_src_vld;
  logic [DW-1:0]   w_src_data [NSTG];
  logic [SHW-1:0]  w_src_amt  [NSTG];
  logic [1:0]      w_src_mode [NSTG];
  logic [TW-1:0]   w_src_tag  [NSTG];
  logic [DW-1:0]   w_ld_data  [NSTG];
  logic [NSTG-1:0] w_en;

  // Input conditioning: out-of-range amounts are resolved here so the stages
  // only ever see amounts below DW.
  logic            w_big;
  logic [DW-1:0]   w_pre_data;
  logic [SHW-1:0]  w_pre_amt;

  always_comb begin
    w_big      = (32'(bus.in_amt) >= 32'(DW));
    w_pre_data = bus.in_data;
    w_pre_amt  = bus.in_amt;
    case (bus.in_mode)
      MODE_ARSH: begin
        if (w_big) begin
          w_pre_data = {DW{bus.in_data[DW-1]}};
          w_pre_amt  = '0;
        end
      end
      MODE_LRSH, MODE_LSH: begin
        if (w_big) begin
          w_pre_data = '0;
          w_pre_amt  = '0;
        end
      end
      default: w_pre_amt = SHW'(32'(bus.in_amt) % 32'(DW));
    endcase
  end

  // Stage k may load when it is empty or when every stage below it up to the
  // output is either empty or moving on this cycle. Written as a running AND
  // from the output end so there is no self-referencing vector.
  always_comb begin
    logic l_full;
    l_full = 1'b1;
    w_en   = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      l_full  = l_full & r_vld_p[k];
      w_en[k] = ~l_full | bus.out_ready;
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_src_vld[k]  = bus.in_valid;
      assign w_src_data[k] = w_pre_data;
      assign w_src_amt[k]  = w_pre_amt;
      assign w_src_mode[k] = bus.in_mode;
      assign w_src_tag[k]  = bus.in_tag;
`ifdef SHIFT_ROUND_EN
      assign w_src_rnd[k]  = (bus.in_mode == MODE_ARSH) &
                             f_round_bit(bus.in_data, bus.in_amt);
`endif
    end else begin : g_body
      assign w_src_vld[k]  = r_vld_p[k-1];
      assign w_src_data[k] = r_data_p[k-1];
      assign w_src_amt[k]  = r_amt_p[k-1];
      assign w_src_mode[k] = r_mode_p[k-1];
      assign w_src_tag[k]  = r_tag_p[k-1];
`ifdef SHIFT_ROUND_EN
      assign w_src_rnd[k]  = r_rnd_p[k-1];
`endif
    end

    if (k == NSTG - 1) begin : g_tail
`ifdef SHIFT_ROUND_EN
      // The round bit is non-zero only for ARSH, so the add is unconditional.
      assign w_ld_data[k] = f_round_add(
        f_shift_step(w_src_data[k], w_src_amt[k], w_src_mode[k], k),
        w_src_rnd[k]);
`else
      assign w_ld_data[k] = f_shift_step(w_src_data[k], w_src_amt[k],
                                         w_src_mode[k], k);
`endif
    end else begin : g_mid
      assign w_ld_data[k] = f_shift_step(w_src_data[k], w_src_amt[k],
                                         w_src_mode[k], k);
    end
  end

  // Stage boundary: valid (and round bit) registers, flushed by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p <= '0;
`ifdef SHIFT_ROUND_EN
      r_rnd_p <= '0;
`endif
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (w_en[k]) begin
          r_vld_p[k] <= w_src_vld[k];
`ifdef SHIFT_ROUND_EN
          r_rnd_p[k] <= w_src_rnd[k];
`endif
        end
      end
    end
  end

  // Stage boundary: datapath registers, qualified by the valid bits only
  always_ff @(posedge clk) begin
    for (int k = 0; k < NSTG; k++) begin
      if (w_en[k]) begin
        r_data_p[k] <= w_ld_data[k];
        r_amt_p[k]  <= w_src_amt[k];
        r_mode_p[k] <= w_src_mode[k];
        r_tag_p[k]  <= w_src_tag[k];
      end
    end
  end

  assign bus.in_ready  = w_en[0];
  assign bus.out_valid = r_vld_p[NSTG-1];
  // Outputs read as zero whenever no result is presented (including reset).
  assign bus.out_data  = r_vld_p[NSTG-1] ? r_data_p[NSTG-1] : '0;
  assign bus.out_tag   = r_vld_p[NSTG-1] ? r_tag_p[NSTG-1]  : '0;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_pipe
// Bench for shift_unit_pipe: directed mode cases, an 8-item burst with an
// output stall, a mid-stream reset flush and a long randomized stream, all
// compared against an arithmetic reference model with an in-order queue.
// Honours SHIFT_ROUND_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_shift_unit_pipe;
  localparam int DW   = 16;
  localparam int SHW  = 4;
  localparam int NSTG = 2;
  localparam int TW   = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_unit_pipe_if #(.DW(DW), .SHW(SHW), .TW(TW)) bus ();

  shift_unit_pipe #(.DW(DW), .SHW(SHW), .NSTG(NSTG), .TW(TW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_out   = 0;
  bit   mon_en  = 1'b0;
  bit   saw_in_stall = 1'b0;
  bit   last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand value.
  function automatic longint floordiv(input longint v, input longint d);
    longint q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input int p,
                                              input logic [1:0] m);
    longint modulus;
    longint div;
    longint v;
    longint q;
    logic [DW-1:0] r;
    modulus = longint'(1) << DW;
    div     = (p < DW) ? (longint'(1) << p) : modulus;
    r       = '0;
    case (m)
      2'd0: begin
        v = longint'(d);
        if (d[DW-1]) v = v - modulus;
        if (p >= DW) q = (v < 0) ? -1 : 0;
        else begin
`ifdef SHIFT_ROUND_EN
          q = (p >= 1) ? floordiv(v + div / 2, div) : v;
`else
          q = floordiv(v, div);
`endif
        end
        r = q[DW-1:0];
      end
      2'd1: r = (p >= DW) ? '0 : DW'(longint'(d) / div);
      2'd2: r = (p >= DW) ? '0 : DW'((longint'(d) * div) % modulus);
      default: begin
        for (int i = 0; i < DW; i++) r[i] = d[(i + p) % DW];
      end
    endcase
    return r;
  endfunction

  // One clock: observe at the falling edge, return 1 time unit after the rise.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (mon_en && rst_n) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(bus.out_valid), 32'(0));
        else begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
          chk("out_tag", 32'(bus.out_tag), 32'(exp_q[0].tag));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.data = ref_shift(bus.in_data, int'(bus.in_amt), bus.in_mode);
        e.tag  = bus.in_tag;
        exp_q.push_back(e);
      end
      if (bus.in_valid && !bus.in_ready) saw_in_stall = 1'b1;
    end
    last_acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic new_item();
    case ($urandom_range(0, 7))
      0:       bus.in_data = 16'h8000;
      1:       bus.in_data = 16'hFFFF;
      2:       bus.in_data = 16'h7FFF;
      default: bus.in_data = DW'($urandom);
    endcase
    bus.in_amt  = SHW'($urandom_range(0, (1 << SHW) - 1));
    bus.in_mode = 2'($urandom_range(0, 3));
    bus.in_tag  = TW'($urandom);
  endtask

  // Stream n items; rnd selects random in_valid/out_ready, otherwise a steady
  // source with out_ready low on cycles 3..6.
  task automatic run_stream(input int n_items, input bit rnd);
    int sent;
    int cyc;
    int budget;
    int start;
    sent   = 0;
    cyc    = 0;
    budget = n_items * 10 + 200;
    start  = n_out;
    new_item();
    bus.in_valid = 1'b1;
    while ((sent < n_items || exp_q.size() > 0) && cyc < budget) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      else     bus.out_ready = !(cyc >= 3 && cyc <= 6);
      step();
      if (last_acc) begin
        sent++;
        if (sent < n_items) new_item();
      end
      if (sent >= n_items) bus.in_valid = 1'b0;
      else if (rnd && (last_acc || !bus.in_valid)) bus.in_valid = ($urandom_range(0, 3) != 0);
      else bus.in_valid = 1'b1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("stream_budget", 32'(cyc < budget), 32'(1));
    chk("stream_count", 32'(n_out - start), 32'(n_items));
  endtask

  task automatic directed(input string name, input logic [DW-1:0] d, input int p,
                          input logic [1:0] m, input logic [TW-1:0] t,
                          input logic [DW-1:0] exp);
    bus.in_data   = d;
    bus.in_amt    = SHW'(p);
    bus.in_mode   = m;
    bus.in_tag    = t;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (NSTG - 1) @(posedge clk);
    #1;
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(1));
    chk({name, "_data"}, 32'(bus.out_data), 32'(exp));
    chk({name, "_tag"}, 32'(bus.out_tag), 32'(t));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_mode   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_out_tag", 32'(bus.out_tag), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;

    directed("arsh_8000_4", 16'h8000, 4, 2'b00, 4'd3, 16'hF800);
    directed("lrsh_8000_4", 16'h8000, 4, 2'b01, 4'd3, 16'h0800);
    directed("lsh_00ff_12", 16'h00FF, 12, 2'b10, 4'd5, 16'hF000);
    directed("ror_0001_1", 16'h0001, 1, 2'b11, 4'd6, 16'h8000);
    directed("arsh_fff0_15", 16'hFFF0, 15, 2'b00, 4'd7, 16'hFFFF);
    directed("ror_p0", 16'hA5C3, 0, 2'b11, 4'd9, 16'hA5C3);
`ifdef SHIFT_ROUND_EN
    directed("arsh_rnd_pos", 16'h0006, 2, 2'b00, 4'd1, 16'h0002);
    directed("arsh_rnd_neg", 16'hFFFA, 2, 2'b00, 4'd2, 16'hFFFF);
`else
    directed("arsh_trunc_pos", 16'h0006, 2, 2'b00, 4'd1, 16'h0001);
    directed("arsh_trunc_neg", 16'hFFFA, 2, 2'b00, 4'd2, 16'hFFFE);
`endif

    // Burst of 8 with an output stall
    mon_en       = 1'b1;
    saw_in_stall = 1'b0;
    run_stream(8, 1'b0);
    chk("burst_in_ready_dropped", 32'(saw_in_stall), 32'(1));

    // Fill the pipe, then reset mid-stream
    start         = n_out;
    bus.out_ready = 1'b0;
    new_item();
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10 && bus.in_ready; i++) begin
      step();
      if (last_acc) new_item();
    end
    chk("full_before_rst", 32'(bus.in_ready), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_out_data", 32'(bus.out_data), 32'(0));
    exp_q.delete();
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'(1));
    bus.out_ready = 1'b1;
    repeat (6) step();
    chk("midrst_no_stale", 32'(n_out - start), 32'(0));

    // Long randomized stream
    run_stream(10000, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
